// File: rtl/seg_scan_multi.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_multi
//  Purpose  : Parametrised multiplexed seven-segment scan driver with
//             hex pass-through or sequential binary-to-BCD (shift-add-3)
//             conversion, leading-zero blanking, per-digit decimal points
//             and a decimal overflow (all-dash) indication.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_multi #(
  parameter int DIGITS = 6,
  parameter int NUM_W  = 24,
  parameter int DIV    = 50000
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic [NUM_W-1:0]  iNum,
  input  logic              iIsHex,
  input  logic              iLoad,
  input  logic [DIGITS-1:0] iDP,
  input  logic              iBlankLZ,
  output logic [7:0]        oSeg,
  output logic [DIGITS-1:0] oSel,
  output logic              oBusy
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = $clog2(NUM_W);
  localparam int SCAN_W = $clog2(DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t              state, state_nxt;

  // conversion datapath
  logic [NUM_W-1:0]    shreg;
  logic [BCD_W-1:0]    bcd;
  logic [BCD_W-1:0]    bcd_adj;
  logic [BCD_W-1:0]    bcd_shift;
  logic                shift_out;
  logic [CNT_W-1:0]    bit_cnt;
  logic                conv_last;
  logic                conv_ovf;
  logic [DIGITS-1:0]   pend_dp;

  // committed display contents
  logic [BCD_W-1:0]    disp;
  logic [DIGITS-1:0]   dp;
  logic                ovf;
  logic [BCD_W-1:0]    hex_ext;

  // scanning
  logic [SCAN_W-1:0]   scan_cnt;
  logic [IDX_W-1:0]    idx;
  logic [DIGITS-1:0]   blank;
  logic                higher_zero;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic [7:0]          seg_nxt;
  logic [DIGITS-1:0]   sel_nxt;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0:    glyph = 7'b1000000;
      4'h1:    glyph = 7'b1111001;
      4'h2:    glyph = 7'b0100100;
      4'h3:    glyph = 7'b0110000;
      4'h4:    glyph = 7'b0011001;
      4'h5:    glyph = 7'b0010010;
      4'h6:    glyph = 7'b0000010;
      4'h7:    glyph = 7'b1111000;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0010000;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b0000011;
      4'hC:    glyph = 7'b1000110;
      4'hD:    glyph = 7'b0100001;
      4'hE:    glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  assign conv_last = (bit_cnt == CNT_W'(NUM_W - 1));
  assign oBusy     = (state == CONV);

  // One shift-add-3 step: correct every BCD nibble >= 5, then shift {bcd, shreg} left
  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
    end
    bcd_shift = {bcd_adj[BCD_W-2:0], shreg[NUM_W-1]};
    shift_out = bcd_adj[BCD_W-1];
  end

  // Hex value zero-extended to the full nibble field
  always_comb begin
    hex_ext              = '0;
    hex_ext[NUM_W-1:0]   = iNum;
  end

  // FSM state register
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: loads are only accepted in IDLE, so a load during CONV is dropped
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iLoad && !iIsHex) state_nxt = CONV;
      CONV:    if (conv_last)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture, conversion and commit; the visible display and its overflow flag
  // only change at commit so the old value stays intact during conversion
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      shreg    <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      conv_ovf <= 1'b0;
      pend_dp  <= '0;
      disp     <= '0;
      dp       <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iLoad) begin
            if (iIsHex) begin
              disp <= hex_ext;
              dp   <= iDP;
              ovf  <= 1'b0;
            end else begin
              shreg    <= iNum;
              pend_dp  <= iDP;
              bcd      <= '0;
              conv_ovf <= 1'b0;
              bit_cnt  <= '0;
            end
          end
        end
        CONV: begin
          bcd      <= bcd_shift;
          shreg    <= {shreg[NUM_W-2:0], 1'b0};
          conv_ovf <= conv_ovf | shift_out;
          bit_cnt  <= bit_cnt + CNT_W'(1);
          if (conv_last) begin
            disp <= bcd_shift;
            dp   <= pend_dp;
            ovf  <= conv_ovf | shift_out;
          end
        end
        default: ;
      endcase
    end
  end

  // Free-running scan timer and digit index
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_W'(DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Leading-zero mask: a digit blanks when it and everything above it is zero
  always_comb begin
    higher_zero = 1'b1;
    blank       = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      higher_zero = higher_zero & (disp[4*k +: 4] == 4'd0);
      blank[k]    = iBlankLZ & ~ovf & higher_zero & (k != 0);
    end
  end

  // Select the current digit and build its segment pattern and enable
  always_comb begin
    cur_nib   = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    sel_nxt   = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib   = disp[4*k +: 4];
        cur_dp    = dp[k];
        cur_blank = blank[k];
        sel_nxt[DIGITS-1-k] = 1'b0;
      end
    end
    seg_nxt = {~cur_dp,
               ovf       ? 7'b0111111 :
               cur_blank ? 7'b1111111 : glyph(cur_nib)};
  end

  // Segments and digit enable registered together so they never disagree
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oSeg <= 8'hFF;
      oSel <= '1;
    end else begin
      oSeg <= seg_nxt;
      oSel <= sel_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_multi
//  Purpose  : Self-checking bench for seg_scan_multi (DIGITS=6, NUM_W=24,
//             DIV=4) against a value-level display model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] num;
  logic        is_hex;
  logic        load;
  logic [5:0]  dp;
  logic        blz;
  logic [7:0]  seg;
  logic [5:0]  sel;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // reference model: the number currently on the display
  longint      mval;
  bit          mhex;
  logic [5:0]  mdp;
  logic [6:0]  glyph_tab [16];

  always #5 clk = ~clk;

  seg_scan_multi #(.DIGITS(6), .NUM_W(24), .DIV(4)) dut (
    .iCLK     (clk),
    .iRST_n   (rst_n),
    .iNum     (num),
    .iIsHex   (is_hex),
    .iLoad    (load),
    .iDP      (dp),
    .iBlankLZ (blz),
    .oSeg     (seg),
    .oSel     (sel),
    .oBusy    (busy)
  );

  // expected pattern of digit k from the displayed value
  function automatic logic [7:0] exp_seg(input int k);
    longint base, p;
    bit     ov, blanked;
    int     nib;
    logic [6:0] g;
    base = mhex ? 16 : 10;
    p    = 1;
    for (int i = 0; i < k; i++) p = p * base;
    ov      = !mhex && (mval >= 64'd1000000);
    nib     = int'((mval / p) % base);
    blanked = blz && !ov && (k != 0) && (mval < p);
    g = ov ? 7'b0111111 : (blanked ? 7'b1111111 : glyph_tab[nib]);
    return {~mdp[k], g};
  endfunction

  function automatic int digit_of_sel(input logic [5:0] s);
    for (int k = 0; k < 6; k++) if (s == ~(6'b000001 << (5 - k))) return k;
    return -1;
  endfunction

  task automatic do_load(input logic [23:0] n, input bit hx, input logic [5:0] d);
    @(negedge clk);
    num = n; is_hex = hx; dp = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // wait (bounded) until digit k is selected, return its segment pattern
  task automatic get_seg(input int k, output logic [7:0] s, output bit ok);
    logic [5:0] want;
    want = ~(6'b000001 << (5 - k));
    ok = 1'b0;
    s  = 8'hxx;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sel === want) begin
        s  = seg;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic read_all(output logic [5:0][7:0] s, output logic [5:0] ok);
    logic [7:0] v;
    bit         o;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      get_seg(k, v, o);
      s[k]  = v;
      ok[k] = o;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; num = '0; is_hex = 1'b0; load = 1'b0; dp = '0; blz = 1'b0;
    mval = 0; mhex = 1'b1; mdp = '0;
    repeat (3) @(negedge clk);
    total++; if (seg !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h want=ff", seg); end
    total++; if (sel !== 6'h3F) begin bad++; $display("FAIL reset_sel got=%b want=111111", sel); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_scan;
    int d;
    logic [5:0] want;
    rst_n = 1'b1;
    for (int n = 1; n <= 48; n++) begin
      @(negedge clk);
      d    = ((n - 1) / 4) % 6;
      want = ~(6'b000001 << (5 - d));
      total++;
      if (sel !== want) begin bad++; $display("FAIL scan_sel n=%0d got=%b want=%b", n, sel, want); end
      if (d == 0) begin
        total++;
        if (seg !== 8'hC0) begin bad++; $display("FAIL scan_zero n=%0d got=%h want=c0", n, seg); end
      end
    end
  endtask

  task automatic test_hex;
    logic [5:0][7:0] s;
    logic [5:0]      ok;
    bit              saw_busy;
    logic [23:0]     v;
    logic [5:0]      d;
    for (int t = 0; t < 4; t++) begin
      v = (t == 0) ? 24'hABC123 : 24'($urandom);
      d = (t == 0) ? 6'd0 : 6'($urandom);
      blz = (t == 0) ? 1'b0 : 1'($urandom);
      do_load(v, 1'b1, d);
      mval = longint'(v); mhex = 1'b1; mdp = d;
      saw_busy = 1'b0;
      repeat (5) begin
        if (busy !== 1'b0) saw_busy = 1'b1;
        @(negedge clk);
      end
      total++;
      if (saw_busy) begin bad++; $display("FAIL hex_busy v=%h got=1 want=0", v); end
      read_all(s, ok);
      for (int k = 0; k < 6; k++) begin
        total++;
        if (!ok[k] || s[k] !== exp_seg(k)) begin
          bad++; $display("FAIL hex_digit v=%h k=%0d got=%h want=%h", v, k, s[k], exp_seg(k));
        end
      end
      if (t == 0) begin
        total++;
        if (s[5] !== 8'h88) begin bad++; $display("FAIL hex_digit5_A got=%h want=88", s[5]); end
      end
    end
  endtask

  task automatic test_decimal;
    logic [5:0][7:0] s;
    logic [5:0]      ok;
    logic [23:0]     v;
    logic [5:0]      d;
    int              cnt, k;
    for (int t = 0; t < 5; t++) begin
      if (t == 0)          v = 24'd987654;
      else if (t % 2 == 1) v = 24'($urandom_range(0, 999999));
      else                 v = 24'($urandom);
      d   = (t == 0) ? 6'd0 : 6'($urandom);
      blz = (t == 0) ? 1'b0 : 1'($urandom);
      do_load(v, 1'b0, d);
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
        cnt++;
        if (cnt == 10) begin
          k = digit_of_sel(sel);
          total++;
          if (k < 0 || seg !== exp_seg(k)) begin
            bad++; $display("FAIL dec_no_tear v=%0d k=%0d got=%h want=%h", v, k, seg, (k < 0) ? 8'h00 : exp_seg(k));
          end
        end
        @(negedge clk);
      end
      total++;
      if (cnt != 24) begin bad++; $display("FAIL dec_busy_len v=%0d got=%0d want=24", v, cnt); end
      mval = longint'(v); mhex = 1'b0; mdp = d;
      read_all(s, ok);
      for (int j = 0; j < 6; j++) begin
        total++;
        if (!ok[j] || s[j] !== exp_seg(j)) begin
          bad++; $display("FAIL dec_digit v=%0d k=%0d got=%h want=%h", v, j, s[j], exp_seg(j));
        end
      end
    end
  endtask

  task automatic test_overflow;
    logic [5:0][7:0] s;
    logic [5:0]      ok;
    blz = 1'b1;
    do_load(24'd1234567, 1'b0, 6'd0);
    mval = 1234567; mhex = 1'b0; mdp = '0;
    repeat (30) @(negedge clk);
    read_all(s, ok);
    for (int k = 0; k < 6; k++) begin
      total++;
      if (!ok[k] || s[k] !== 8'hBF) begin bad++; $display("FAIL ovf_dash k=%0d got=%h want=bf", k, s[k]); end
    end
    do_load(24'h000001, 1'b1, 6'd0);
    mval = 1; mhex = 1'b1; mdp = '0;
    read_all(s, ok);
    for (int k = 0; k < 6; k++) begin
      total++;
      if (!ok[k] || s[k] !== exp_seg(k)) begin
        bad++; $display("FAIL ovf_clear k=%0d got=%h want=%h", k, s[k], exp_seg(k));
      end
    end
  endtask

  task automatic test_blank;
    logic [5:0][7:0] s;
    logic [5:0]      ok;
    logic [7:0]      v;
    bit              o;
    blz = 1'b1;
    do_load(24'd42, 1'b0, 6'b000100);
    mval = 42; mhex = 1'b0; mdp = 6'b000100;
    repeat (30) @(negedge clk);
    read_all(s, ok);
    for (int k = 0; k < 6; k++) begin
      total++;
      if (!ok[k] || s[k] !== exp_seg(k)) begin
        bad++; $display("FAIL blank_digit k=%0d got=%h want=%h", k, s[k], exp_seg(k));
      end
    end
    total++;
    if (s[2] !== 8'h7F) begin bad++; $display("FAIL blank_dp2 got=%h want=7f", s[2]); end
    blz = 1'b0;
    repeat (2) @(negedge clk);
    get_seg(2, v, o);
    total++;
    if (!o || v !== 8'h40) begin bad++; $display("FAIL noblank_dp2 got=%h want=40", v); end
  endtask

  task automatic test_back_to_back;
    logic [5:0][7:0] s;
    logic [5:0]      ok;
    int              cnt;
    blz = 1'b0;
    do_load(24'd111111, 1'b0, 6'd0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 5) begin num = 24'd222222; is_hex = 1'b0; load = 1'b1; end
      else load = 1'b0;
      @(negedge clk);
    end
    load = 1'b0;
    total++;
    if (cnt != 24) begin bad++; $display("FAIL b2b_busy_len got=%0d want=24", cnt); end
    mval = 111111; mhex = 1'b0; mdp = '0;
    read_all(s, ok);
    for (int k = 0; k < 6; k++) begin
      total++;
      if (!ok[k] || s[k] !== exp_seg(k)) begin
        bad++; $display("FAIL b2b_digit k=%0d got=%h want=%h", k, s[k], exp_seg(k));
      end
    end
  endtask

  task automatic test_reset_abort;
    logic [5:0][7:0] s;
    logic [5:0]      ok;
    blz = 1'b0;
    do_load(24'd555555, 1'b0, 6'h3F);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (seg !== 8'hFF) begin bad++; $display("FAIL abort_seg got=%h want=ff", seg); end
    total++; if (sel !== 6'h3F) begin bad++; $display("FAIL abort_sel got=%b want=111111", sel); end
    @(negedge clk);
    rst_n = 1'b1;
    mval = 0; mhex = 1'b1; mdp = '0;
    read_all(s, ok);
    for (int k = 0; k < 6; k++) begin
      total++;
      if (!ok[k] || s[k] !== 8'hC0) begin bad++; $display("FAIL abort_disp k=%0d got=%h want=c0", k, s[k]); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b want=0", busy); end
  endtask

  initial begin
    glyph_tab[0]  = 7'b1000000; glyph_tab[1]  = 7'b1111001;
    glyph_tab[2]  = 7'b0100100; glyph_tab[3]  = 7'b0110000;
    glyph_tab[4]  = 7'b0011001; glyph_tab[5]  = 7'b0010010;
    glyph_tab[6]  = 7'b0000010; glyph_tab[7]  = 7'b1111000;
    glyph_tab[8]  = 7'b0000000; glyph_tab[9]  = 7'b0010000;
    glyph_tab[10] = 7'b0001000; glyph_tab[11] = 7'b0000011;
    glyph_tab[12] = 7'b1000110; glyph_tab[13] = 7'b0100001;
    glyph_tab[14] = 7'b0000110; glyph_tab[15] = 7'b0001110;
    test_reset;
    test_scan;
    test_hex;
    test_decimal;
    test_overflow;
    test_blank;
    test_back_to_back;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
